// File: rtl/matrix_inv2x2_stream_pkg.sv
// Format constants, FSM encoding and the round/saturate helpers shared by the
// streaming 2x2 inverter and the single-cycle inverter.
package matrix_inv_pkg;

  localparam int W      = 16;
  localparam int FRAC   = 14;
  localparam int REC_F  = 16;
  localparam int RW     = 32;
  localparam int Q_BITS = 2*FRAC + REC_F + 1;
  localparam int DET_W  = 2*W + 1;
  localparam int P_W    = W + RW + 1;

  localparam logic signed [P_W-1:0] RND_HALF = P_W'(64'sd1 <<< (REC_F-1));
  localparam logic signed [P_W-1:0] OUT_MAX  = P_W'((64'sd1 <<< (W-1)) - 64'sd1);
  localparam logic signed [P_W-1:0] OUT_MIN  = -P_W'(64'sd1 <<< (W-1));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DET,
    ST_DIV,
    ST_MUL,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [W-1:0] val;
    logic         sat;
  } sat_res_t;

  function automatic logic signed [P_W-1:0] round_half_up(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] biased;
    biased = p + RND_HALF;
    return biased >>> REC_F;
  endfunction

  function automatic sat_res_t saturate_w(input logic signed [P_W-1:0] x);
    sat_res_t r;
    r.sat = 1'b1;
    if (x > OUT_MAX) begin
      r.val = OUT_MAX[W-1:0];
    end else if (x < OUT_MIN) begin
      r.val = OUT_MIN[W-1:0];
    end else begin
      r.val = x[W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_inv2x2_stream_if.sv
// Matrix-in / inverse-out handshake bundle: master is the channel-estimate
// front end, slave is the inverter.
interface matrix_inv2x2_stream_if
  import matrix_inv_pkg::*;
();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_inv;
  logic [W-1:0] b_inv;
  logic [W-1:0] c_inv;
  logic [W-1:0] d_inv;
  logic         err_singular;
  logic         err_sat;

  modport master (
    output in_valid, a, b, c, d, out_ready,
    input  in_ready, out_valid, a_inv, b_inv, c_inv, d_inv, err_singular, err_sat
  );

  modport slave (
    input  in_valid, a, b, c, d, out_ready,
    output in_ready, out_valid, a_inv, b_inv, c_inv, d_inv, err_singular, err_sat
  );
endinterface

// File: rtl/matrix_inv2x2_stream_recip_div_seq.sv
// Restoring divider computing 2^(QB-1) / denominator, one quotient bit per
// cycle MSB first, with the result clamped to the signed RW-bit range.
module recip_div_seq
  import matrix_inv_pkg::*;
#(
  parameter int DEN_W = DET_W,
  parameter int QB    = Q_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [DEN_W-1:0] denominator_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [RW-1:0]    quotient_o,
  output logic             clamp_o
);
  localparam int            CNT_W    = $clog2(QB + 1);
  localparam logic [QB-1:0] REC_MAX  = QB'((64'd1 << (RW-1)) - 64'd1);
  localparam logic [QB-1:0] NUM_INIT = {1'b1, {(QB-1){1'b0}}};

  logic [DEN_W-1:0] den_q;
  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] rem_d;
  logic [DEN_W-1:0] rem_shift;
  logic [DEN_W-1:0] rem_sub;
  logic [QB-1:0]    num_q;
  logic [QB-1:0]    quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             q_bit;

  // The bit shifted out of rem_q stands for 2^DEN_W, which always exceeds
  // the denominator, so it forces a subtract without widening the datapath.
  assign rem_shift = {rem_q[DEN_W-2:0], num_q[QB-1]};
  assign q_bit     = rem_q[DEN_W-1] | (rem_shift >= den_q);
  assign rem_sub   = rem_shift - den_q;
  assign rem_d     = q_bit ? rem_sub : rem_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      den_q  <= '0;
      rem_q  <= '0;
      num_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      den_q  <= denominator_i;
      rem_q  <= '0;
      num_q  <= NUM_INIT;
      quo_q  <= '0;
      cnt_q  <= CNT_W'(QB);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      num_q <= {num_q[QB-2:0], 1'b0};
      quo_q <= {quo_q[QB-2:0], q_bit};
      cnt_q <= cnt_q - CNT_W'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

  // done marks the final iteration so the parent steps on the same edge
  // that lands the last quotient bit.
  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CNT_W'(1));
  assign clamp_o    = quo_q > REC_MAX;
  assign quotient_o = clamp_o ? REC_MAX[RW-1:0] : quo_q[RW-1:0];

endmodule

// File: rtl/matrix_inv2x2_stream.sv
// Handshaked 2x2 matrix inverter: det, sequential reciprocal, adjugate scale,
// round-half-up and saturate back to the element format.
module matrix_inv2x2_stream
  import matrix_inv_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  matrix_inv2x2_stream_if.slave bus
);
  state_e state_q, state_d;

  logic signed [W-1:0] a_q, b_q, c_q, d_q;
  logic                sign_q;
  logic [W-1:0]        inv_q [4];
  logic                err_singular_q;
  logic                err_sat_q;

  logic signed [2*W-1:0]   prod_ad, prod_bc;
  logic signed [DET_W-1:0] det_raw;
  logic [DET_W-1:0]        det_abs;
  logic                    det_zero;
  logic                    div_start, div_busy, div_done, div_clamp;
  logic [RW-1:0]           div_quot;
  logic signed [RW-1:0]    inv_det;
  logic signed [W:0]       adj_w  [4];
  logic signed [P_W-1:0]   prod_w [4];
  sat_res_t                res_w  [4];
  logic [3:0]              lane_sat;

  assign prod_ad  = (2*W)'(a_q) * (2*W)'(d_q);
  assign prod_bc  = (2*W)'(b_q) * (2*W)'(c_q);
  assign det_raw  = DET_W'(prod_ad) - DET_W'(prod_bc);
  assign det_abs  = det_raw[DET_W-1] ? -det_raw : det_raw;
  assign det_zero = (det_raw == '0);

  recip_div_seq #(
    .DEN_W (DET_W),
    .QB    (Q_BITS)
  ) u_recip (
    .clk           (clk),
    .reset         (reset),
    .start_i       (div_start),
    .denominator_i (det_abs),
    .busy_o        (div_busy),
    .done_o        (div_done),
    .quotient_o    (div_quot),
    .clamp_o       (div_clamp)
  );

  assign inv_det = sign_q ? -$signed(div_quot) : $signed(div_quot);

  // Negations are one bit wider than the element so -(-2^(W-1)) stays positive.
  assign adj_w[0] = (W+1)'(d_q);
  assign adj_w[1] = -((W+1)'(b_q));
  assign adj_w[2] = -((W+1)'(c_q));
  assign adj_w[3] = (W+1)'(a_q);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign prod_w[gi]   = P_W'(adj_w[gi]) * P_W'(inv_det);
    assign res_w[gi]    = saturate_w(round_half_up(prod_w[gi]));
    assign lane_sat[gi] = res_w[gi].sat;
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_DET;
      ST_DET: begin
        if (det_zero) begin
          state_d = ST_DONE;
        end else begin
          div_start = !div_busy;
          state_d   = ST_DIV;
        end
      end
      ST_DIV:  if (div_done) state_d = ST_MUL;
      ST_MUL:  state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q            <= '0;
      b_q            <= '0;
      c_q            <= '0;
      d_q            <= '0;
      sign_q         <= 1'b0;
      err_singular_q <= 1'b0;
      err_sat_q      <= 1'b0;
      for (int i = 0; i < 4; i++) inv_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.a;
            b_q <= bus.b;
            c_q <= bus.c;
            d_q <= bus.d;
          end
        end
        ST_DET: begin
          sign_q <= det_raw[DET_W-1];
          if (det_zero) begin
            for (int i = 0; i < 4; i++) inv_q[i] <= '0;
            err_singular_q <= 1'b1;
            err_sat_q      <= 1'b0;
          end
        end
        ST_MUL: begin
          for (int i = 0; i < 4; i++) inv_q[i] <= res_w[i].val;
          err_singular_q <= 1'b0;
          err_sat_q      <= div_clamp | (|lane_sat);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.a_inv        = inv_q[0];
  assign bus.b_inv        = inv_q[1];
  assign bus.c_inv        = inv_q[2];
  assign bus.d_inv        = inv_q[3];
  assign bus.err_singular = err_singular_q;
  assign bus.err_sat      = err_sat_q;

endmodule

// File: tb/tb_matrix_inv2x2_stream.sv
// Self-checking bench: fixed vector table, randomized matrices against an
// integer reference model, stall and mid-division reset sequences.
module tb_matrix_inv2x2_stream;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  matrix_inv2x2_stream_if bus();

  matrix_inv2x2_stream dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a, b, c, d;
    logic [15:0] ea, eb, ec, ed;
    bit          es, et;
  } vec_t;

  vec_t              vecs [7];
  logic [15:0]       ra, rb, rc, rd;
  logic [3:0][15:0]  rexp;
  bit                rs, rt;
  int                nv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inverse straight from the arithmetic definition: 2^44/|det| reciprocal,
  // clamp, adjugate product, round half-up at bit 16, saturate to 16 bits.
  function automatic void model(input logic [15:0] a, b, c, d,
                                output logic [3:0][15:0] r, output bit sing, output bit sat);
    longint sa, sb, sc, sd, det, mag, q, inv, p, v;
    longint adj [4];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sc = longint'($signed(c));
    sd = longint'($signed(d));
    det  = sa * sd - sb * sc;
    r    = '0;
    sing = (det == 0);
    sat  = 1'b0;
    if (!sing) begin
      mag = (det < 0) ? -det : det;
      q   = (64'sd1 <<< 44) / mag;
      if (q > 64'sd2147483647) begin
        q   = 64'sd2147483647;
        sat = 1'b1;
      end
      inv = (det < 0) ? -q : q;
      adj = '{sd, -sb, -sc, sa};
      for (int i = 0; i < 4; i++) begin
        p = adj[i] * inv;
        v = (p + 64'sd32768) >>> 16;
        if (v > 64'sd32767) begin
          v = 64'sd32767;
          sat = 1'b1;
        end else if (v < -64'sd32768) begin
          v = -64'sd32768;
          sat = 1'b1;
        end
        r[i] = v[15:0];
      end
    end
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":in_ready_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_txn(input logic [15:0] a, b, c, d, input logic [3:0][15:0] exp,
                        input bit exp_s, input bit exp_t, input int stall,
                        input bit early_ready, input string tag);
    int lat;
    int exp_lat;
    exp_lat = exp_s ? 1 : 47;
    wait_idle(tag);
    bus.a = a; bus.b = b; bus.c = c; bus.d = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.c = 16'($urandom); bus.d = 16'($urandom);
    bus.out_ready = early_ready;
    chk({tag, ":in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    for (int s = 0; s <= stall; s++) begin
      chk({tag, ":out_valid"},    32'(bus.out_valid),    32'd1);
      chk({tag, ":in_ready_hold"}, 32'(bus.in_ready),    32'd0);
      chk({tag, ":a_inv"},        32'(bus.a_inv),        32'(exp[0]));
      chk({tag, ":b_inv"},        32'(bus.b_inv),        32'(exp[1]));
      chk({tag, ":c_inv"},        32'(bus.c_inv),        32'(exp[2]));
      chk({tag, ":d_inv"},        32'(bus.d_inv),        32'(exp[3]));
      chk({tag, ":err_singular"}, 32'(bus.err_singular), 32'(exp_s));
      chk({tag, ":err_sat"},      32'(bus.err_sat),      32'(exp_t));
      bus.out_ready = (s == stall);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk({tag, ":out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ":in_ready_back"},  32'(bus.in_ready),  32'd1);
    $display("txn %s in=%h,%h,%h,%h exp=%h,%h,%h,%h sing=%0b sat=%0b lat=%0d stall=%0d",
             tag, a, b, c, d, exp[0], exp[1], exp[2], exp[3], exp_s, exp_t, lat, stall);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0};
    vecs[1] = '{16'h4000, 16'h2000, 16'h0000, 16'h4000, 16'h4000, 16'hE000, 16'h0000, 16'h4000, 1'b0, 1'b0};
    vecs[2] = '{16'h2000, 16'h0000, 16'h0000, 16'h2000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'hE000, 16'h0000, 16'h0000, 16'hE000, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'hE000, 16'hE000, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset:in_ready",     32'(bus.in_ready),     32'd1);
    chk("reset:out_valid",    32'(bus.out_valid),    32'd0);
    chk("reset:a_inv",        32'(bus.a_inv),        32'd0);
    chk("reset:b_inv",        32'(bus.b_inv),        32'd0);
    chk("reset:c_inv",        32'(bus.c_inv),        32'd0);
    chk("reset:d_inv",        32'(bus.d_inv),        32'd0);
    chk("reset:err_singular", 32'(bus.err_singular), 32'd0);
    chk("reset:err_sat",      32'(bus.err_sat),      32'd0);

    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
             {vecs[i].ed, vecs[i].ec, vecs[i].eb, vecs[i].ea},
             vecs[i].es, vecs[i].et, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Abort an identity matrix 20 cycles into the division.
    wait_idle("abort");
    bus.a = 16'h4000; bus.b = 16'h0000; bus.c = 16'h0000; bus.d = 16'h4000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (21) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #2;
    chk("abort:out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort:in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort:a_inv",     32'(bus.a_inv),     32'd0);
    chk("abort:err_sat",   32'(bus.err_sat),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    nv = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.out_valid) nv++;
    end
    chk("abort:no_out_valid", 32'(nv), 32'd0);
    do_txn(16'h4000, 16'h0000, 16'h0000, 16'h4000, {16'h4000, 16'h0000, 16'h0000, 16'h4000},
           1'b0, 1'b0, 0, 1'b0, "post_reset");

    do_txn(16'h4000, 16'h0000, 16'h0000, 16'h4000, {16'h4000, 16'h0000, 16'h0000, 16'h4000},
           1'b0, 1'b0, 10, 1'b0, "stall10");

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 16'($urandom); rd = 16'($urandom);
      case (i % 3)
        1: begin
          ra = 16'($urandom_range(0, 511)) - 16'd256;
          rb = 16'($urandom_range(0, 511)) - 16'd256;
          rc = 16'($urandom_range(0, 511)) - 16'd256;
          rd = 16'($urandom_range(0, 511)) - 16'd256;
        end
        2: begin
          rc = ra;
          rd = rb;
        end
        default: ;
      endcase
      model(ra, rb, rc, rd, rexp, rs, rt);
      do_txn(ra, rb, rc, rd, rexp, rs, rt,
             (i % 4 == 0) ? int'($urandom_range(1, 3)) : 0,
             (i % 5 == 1), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
